// File: rtl/usb_in_scheduler.sv
// usb_in_scheduler: sequences the packet encoder for IN transactions on EP0 and two bulk streams.
// Define USB_IN_NAK_STATS_EN to add nak_count_o, with per-endpoint saturating NAK counters.
//
// state  | meaning
// IDLE   | waiting for an IN token addressed to an enabled endpoint
// DECIDE | choose STALL, NAK or data for the selected endpoint
// HSK    | handshake request held until the encoder reports it sent
// DSTART | waiting for the encoder to go idle, then start the data packet
// DXFER  | selected endpoint stream muxed straight through to the encoder
// WACK   | waiting for the host handshake, bounded by the ACK timer
module usb_in_scheduler #(
  parameter int unsigned EPA_NUM     = 1,
  parameter int unsigned EPB_NUM     = 2,
  parameter int unsigned ACK_TIMEOUT = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  usb_addr_i,
  input  logic        tok_recv_i,
  input  logic [1:0]  tok_type_i,
  input  logic [6:0]  tok_addr_i,
  input  logic [3:0]  tok_endp_i,
  input  logic        hsk_recv_i,
  input  logic [1:0]  hsk_type_i,
  output logic        hsk_send_o,
  output logic [1:0]  hsk_type_o,
  input  logic        hsk_sent_i,
  output logic        trn_send_o,
  output logic [1:0]  trn_type_o,
  input  logic        trn_busy_i,
  input  logic        trn_done_i,
  output logic        tx_tvalid_o,
  input  logic        tx_tready_i,
  output logic        tx_tlast_o,
  output logic [7:0]  tx_tdata_o,
  input  logic [2:0]  ep_tvalid_i,
  output logic [2:0]  ep_tready_o,
  input  logic [2:0]  ep_tlast_i,
  input  logic [23:0] ep_tdata_i,
  input  logic [2:0]  ep_halt_i,
  input  logic [2:0]  ep_tgl_clr_i,
  input  logic [2:0]  ep_tgl_set_i,
`ifdef USB_IN_NAK_STATS_EN
  output logic [23:0] nak_count_o,
`endif
  output logic [2:0]  ep_done_o,
  output logic        busy_o
);

  localparam int unsigned TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ACK_TIMEOUT);
  localparam logic [3:0] EPA_ENDP = 4'(EPA_NUM);
  localparam logic [3:0] EPB_ENDP = 4'(EPB_NUM);
  localparam logic [2:0] EP_EN = {(EPB_NUM != 0), (EPA_NUM != 0), 1'b1};

  localparam logic [1:0] PID_DATA0 = 2'b00;
  localparam logic [1:0] PID_DATA1 = 2'b10;
  localparam logic [1:0] HSK_ACK   = 2'b00;
  localparam logic [1:0] HSK_NAK   = 2'b10;
  localparam logic [1:0] HSK_STALL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_HSK,
    S_DSTART,
    S_DXFER,
    S_WACK
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sel_q, sel_d;
  logic [2:0]      tgl_q, tgl_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            hsk_send_q, hsk_send_d;
  logic [1:0]      hsk_type_q, hsk_type_d;
  logic            trn_send_q, trn_send_d;
  logic [1:0]      trn_type_q, trn_type_d;
  logic [2:0]      ep_done_q, ep_done_d;
  logic            busy_q, busy_d;

  logic            tok_hit;
  logic [1:0]      tok_idx;
  logic            xfer;
  logic [2:0]      ready_raw;

  always_comb begin
    tok_hit = 1'b0;
    tok_idx = 2'd0;
    if (tok_recv_i && (tok_type_i == 2'b10) && (tok_addr_i == usb_addr_i)) begin
      if (tok_endp_i == 4'd0) begin
        tok_hit = 1'b1;
        tok_idx = 2'd0;
      end else if (EP_EN[1] && (tok_endp_i == EPA_ENDP)) begin
        tok_hit = 1'b1;
        tok_idx = 2'd1;
      end else if (EP_EN[2] && (tok_endp_i == EPB_ENDP)) begin
        tok_hit = 1'b1;
        tok_idx = 2'd2;
      end
    end
  end

  // Data path is a pure mux during DXFER so the encoder sees the source with no added latency.
  assign xfer = (state_q == S_DXFER);

  always_comb begin
    ready_raw = 3'b000;
    if (xfer) ready_raw[sel_q] = tx_tready_i;
    ep_tready_o = ready_raw & EP_EN;
    tx_tvalid_o = xfer & ep_tvalid_i[sel_q];
    tx_tlast_o  = xfer & ep_tlast_i[sel_q];
    tx_tdata_o  = xfer ? ep_tdata_i[{sel_q, 3'b000} +: 8] : 8'h00;
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    tgl_d      = tgl_q;
    timer_d    = timer_q;
    hsk_type_d = hsk_type_q;
    trn_type_d = trn_type_q;
    trn_send_d = 1'b0;
    ep_done_d  = 3'b000;

    case (state_q)
      S_IDLE: begin
        if (tok_hit) begin
          sel_d   = tok_idx;
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (ep_halt_i[sel_q]) begin
          hsk_type_d = HSK_STALL;
          state_d    = S_HSK;
        end else if (!ep_tvalid_i[sel_q]) begin
          hsk_type_d = HSK_NAK;
          state_d    = S_HSK;
        end else begin
          state_d = S_DSTART;
        end
      end
      S_HSK: begin
        if (hsk_sent_i) state_d = S_IDLE;
      end
      S_DSTART: begin
        if (!trn_busy_i) begin
          trn_send_d = 1'b1;
          trn_type_d = tgl_q[sel_q] ? PID_DATA1 : PID_DATA0;
          state_d    = S_DXFER;
        end
      end
      S_DXFER: begin
        if (trn_done_i) begin
          timer_d = TIMER_LOAD;
          state_d = S_WACK;
        end
      end
      S_WACK: begin
        // A lost or refused ACK leaves the toggle alone so the source replays with the same PID.
        if (hsk_recv_i) begin
          if (hsk_type_i == HSK_ACK) begin
            tgl_d[sel_q]     = ~tgl_q[sel_q];
            ep_done_d[sel_q] = 1'b1;
          end
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int i = 0; i < 3; i++) begin
      if (ep_tgl_set_i[i])      tgl_d[i] = 1'b1;
      else if (ep_tgl_clr_i[i]) tgl_d[i] = 1'b0;
    end

    hsk_send_d = (state_d == S_HSK);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= 2'd0;
      tgl_q      <= 3'b000;
      timer_q    <= '0;
      hsk_send_q <= 1'b0;
      hsk_type_q <= 2'b00;
      trn_send_q <= 1'b0;
      trn_type_q <= 2'b00;
      ep_done_q  <= 3'b000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tgl_q      <= tgl_d;
      timer_q    <= timer_d;
      hsk_send_q <= hsk_send_d;
      hsk_type_q <= hsk_type_d;
      trn_send_q <= trn_send_d;
      trn_type_q <= trn_type_d;
      ep_done_q  <= ep_done_d;
      busy_q     <= busy_d;
    end
  end

  assign hsk_send_o = hsk_send_q;
  assign hsk_type_o = hsk_type_q;
  assign trn_send_o = trn_send_q;
  assign trn_type_o = trn_type_q;
  assign ep_done_o  = ep_done_q;
  assign busy_o     = busy_q;

`ifdef USB_IN_NAK_STATS_EN
  logic            nak_inc;
  logic [2:0][7:0] nak_cnt_q, nak_cnt_d;

  assign nak_inc = (state_q == S_DECIDE) && !ep_halt_i[sel_q] && !ep_tvalid_i[sel_q];

  always_comb begin
    nak_cnt_d = nak_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (ep_tgl_clr_i[i]) begin
        nak_cnt_d[i] = 8'h00;
      end else if (nak_inc && (sel_q == 2'(i)) && (nak_cnt_q[i] != 8'hFF)) begin
        nak_cnt_d[i] = nak_cnt_q[i] + 8'h01;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) nak_cnt_q <= '0;
    else       nak_cnt_q <= nak_cnt_d;
  end

  assign nak_count_o = nak_cnt_q;
`endif

endmodule

// File: tb/tb_usb_in_scheduler.sv
// Self-checking bench for usb_in_scheduler: data/ACK, NAK, STALL, timeout, toggle overrides, reset.
// Streamed bytes are pushed to a scoreboard when loaded into the source and popped at the encoder side.
module tb_usb_in_scheduler;

  localparam int ACK_TIMEOUT = 1023;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  usb_addr_i;
  logic        tok_recv_i;
  logic [1:0]  tok_type_i;
  logic [6:0]  tok_addr_i;
  logic [3:0]  tok_endp_i;
  logic        hsk_recv_i;
  logic [1:0]  hsk_type_i;
  logic        hsk_send_o;
  logic [1:0]  hsk_type_o;
  logic        hsk_sent_i;
  logic        trn_send_o;
  logic [1:0]  trn_type_o;
  logic        trn_busy_i;
  logic        trn_done_i;
  logic        tx_tvalid_o;
  logic        tx_tready_i;
  logic        tx_tlast_o;
  logic [7:0]  tx_tdata_o;
  logic [2:0]  ep_tvalid_i;
  logic [2:0]  ep_tready_o;
  logic [2:0]  ep_tlast_i;
  logic [23:0] ep_tdata_i;
  logic [2:0]  ep_halt_i;
  logic [2:0]  ep_tgl_clr_i;
  logic [2:0]  ep_tgl_set_i;
  logic [2:0]  ep_done_o;
  logic        busy_o;
`ifdef USB_IN_NAK_STATS_EN
  logic [23:0] nak_count_o;
`endif

  int checks = 0;
  int failures = 0;
  logic [8:0] sb_q[$];
  logic [2:0] tgl_m;

  usb_in_scheduler #(.EPA_NUM(1), .EPB_NUM(2), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clock(clock), .reset(reset), .usb_addr_i(usb_addr_i),
    .tok_recv_i(tok_recv_i), .tok_type_i(tok_type_i), .tok_addr_i(tok_addr_i), .tok_endp_i(tok_endp_i),
    .hsk_recv_i(hsk_recv_i), .hsk_type_i(hsk_type_i), .hsk_send_o(hsk_send_o), .hsk_type_o(hsk_type_o),
    .hsk_sent_i(hsk_sent_i), .trn_send_o(trn_send_o), .trn_type_o(trn_type_o),
    .trn_busy_i(trn_busy_i), .trn_done_i(trn_done_i),
    .tx_tvalid_o(tx_tvalid_o), .tx_tready_i(tx_tready_i), .tx_tlast_o(tx_tlast_o), .tx_tdata_o(tx_tdata_o),
    .ep_tvalid_i(ep_tvalid_i), .ep_tready_o(ep_tready_o), .ep_tlast_i(ep_tlast_i), .ep_tdata_i(ep_tdata_i),
    .ep_halt_i(ep_halt_i), .ep_tgl_clr_i(ep_tgl_clr_i), .ep_tgl_set_i(ep_tgl_set_i),
`ifdef USB_IN_NAK_STATS_EN
    .nak_count_o(nak_count_o),
`endif
    .ep_done_o(ep_done_o), .busy_o(busy_o)
  );

  always #5 clock = ~clock;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    usb_addr_i = 7'd5;
    tok_recv_i = 1'b0; tok_type_i = 2'b00; tok_addr_i = 7'd0; tok_endp_i = 4'd0;
    hsk_recv_i = 1'b0; hsk_type_i = 2'b00; hsk_sent_i = 1'b0;
    trn_busy_i = 1'b0; trn_done_i = 1'b0; tx_tready_i = 1'b0;
    ep_tvalid_i = 3'b000; ep_tlast_i = 3'b000; ep_tdata_i = 24'h0;
    ep_halt_i = 3'b000; ep_tgl_clr_i = 3'b000; ep_tgl_set_i = 3'b000;
  endtask

  task automatic set_src(input int idx, input logic v, input logic [7:0] d, input logic l);
    ep_tvalid_i[idx] = v;
    ep_tdata_i[idx*8 +: 8] = d;
    ep_tlast_i[idx] = l;
  endtask

  task automatic send_token(input logic [1:0] typ, input logic [6:0] addr, input logic [3:0] endp);
    @(negedge clock);
    tok_recv_i = 1'b1; tok_type_i = typ; tok_addr_i = addr; tok_endp_i = endp;
    @(negedge clock);
    tok_recv_i = 1'b0;
    #1;
  endtask

  // Token -> trn_send -> streamed bytes -> trn_done; returns with the DUT waiting for the host handshake.
  task automatic run_packet(input int idx, input int n, input logic [1:0] exp_type);
    logic [7:0] pkt[16];
    logic [8:0] exp;
    bit seen;
    int j, cyc;
    for (int k = 0; k < n; k++) begin
      pkt[k] = 8'($urandom_range(0, 255));
      sb_q.push_back({(k == n - 1), pkt[k]});
    end
    set_src(idx, 1'b1, pkt[0], (n == 1));
    send_token(2'b10, 7'd5, 4'(idx));
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (trn_send_o) seen = 1;
      else begin @(negedge clock); #1; end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL trn_send_ep%0d: actual=no pulse required=pulse within 20 cycles", idx);
    end else if (trn_type_o !== exp_type) begin
      failures++;
      $display("FAIL trn_type_ep%0d: actual=%b required=%b", idx, trn_type_o, exp_type);
    end
    tx_tready_i = 1'b1;
    #1;
    j = 0; cyc = 0;
    while (j < n && cyc < 50) begin
      if (cyc == 1) begin
        checks++;
        if (trn_send_o !== 1'b0) begin
          failures++;
          $display("FAIL trn_send_width: actual=%b required=0", trn_send_o);
        end
      end
      if (tx_tvalid_o && tx_tready_i) begin
        exp = sb_q.pop_front();
        checks++;
        if ({tx_tlast_o, tx_tdata_o} !== exp || ep_tready_o !== 3'(1 << idx)) begin
          failures++;
          $display("FAIL stream_ep%0d_byte%0d: actual last/data=%b/%h ready=%b required=%b/%h ready=%b",
                   idx, j, tx_tlast_o, tx_tdata_o, ep_tready_o, exp[8], exp[7:0], 3'(1 << idx));
        end
        j++;
      end
      @(negedge clock);
      if (j < n) set_src(idx, 1'b1, pkt[j], (j == n - 1));
      else       set_src(idx, 1'b0, 8'h00, 1'b0);
      #1;
      cyc++;
    end
    checks++;
    if (j != n) begin
      failures++;
      $display("FAIL stream_count_ep%0d: actual=%0d required=%0d", idx, j, n);
      sb_q.delete();
    end
    tx_tready_i = 1'b0;
    trn_done_i = 1'b1;
    @(negedge clock);
    trn_done_i = 1'b0;
    #1;
  endtask

  task automatic host_ack(input int idx, input logic set_same_cycle);
    hsk_recv_i = 1'b1; hsk_type_i = 2'b00;
    if (set_same_cycle) ep_tgl_set_i[idx] = 1'b1;
    @(negedge clock);
    hsk_recv_i = 1'b0; ep_tgl_set_i = 3'b000;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if ({hsk_send_o, hsk_type_o, trn_send_o, trn_type_o, tx_tvalid_o, tx_tlast_o, tx_tdata_o,
         ep_tready_o, ep_done_o, busy_o} !== 22'h0) begin
      failures++;
      $display("FAIL reset_outputs: actual hsk=%b/%b trn=%b/%b tx=%b/%b/%h rdy=%b done=%b busy=%b required=all 0",
               hsk_send_o, hsk_type_o, trn_send_o, trn_type_o, tx_tvalid_o, tx_tlast_o, tx_tdata_o,
               ep_tready_o, ep_done_o, busy_o);
    end
    reset = 1'b0;
    tgl_m = 3'b000;
    @(negedge clock); #1;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_busy: actual=%b required=0", busy_o);
    end
  endtask

  task automatic test_ignored_tokens();
    logic [1:0] typ[4]  = '{2'b10, 2'b00, 2'b11, 2'b10};
    logic [6:0] addr[4] = '{7'd6, 7'd5, 7'd5, 7'd5};
    logic [3:0] endp[4] = '{4'd1, 4'd1, 4'd0, 4'd3};
    bit bad;
    set_src(0, 1'b1, 8'h55, 1'b1);
    set_src(1, 1'b1, 8'h66, 1'b1);
    for (int t = 0; t < 4; t++) begin
      send_token(typ[t], addr[t], endp[t]);
      bad = 0;
      for (int c = 0; c < 4; c++) begin
        if (busy_o !== 1'b0 || trn_send_o !== 1'b0 || hsk_send_o !== 1'b0 || ep_tready_o !== 3'b000) bad = 1;
        @(negedge clock); #1;
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL ignored_token_%0d: actual busy=%b trn=%b hsk=%b required=all 0",
                 t, busy_o, trn_send_o, hsk_send_o);
      end
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
    set_src(1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_bulk_ack();
    run_packet(1, 4, tgl_m[1] ? 2'b10 : 2'b00);
    host_ack(1, 1'b0);
    tgl_m[1] = ~tgl_m[1];
    checks++;
    if (ep_done_o !== 3'b010 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL bulk_ack_done: actual done=%b busy=%b required done=010 busy=0", ep_done_o, busy_o);
    end
    @(negedge clock); #1;
    checks++;
    if (ep_done_o !== 3'b000) begin
      failures++;
      $display("FAIL bulk_ack_done_pulse: actual=%b required=000", ep_done_o);
    end
    run_packet(1, 3, tgl_m[1] ? 2'b10 : 2'b00);
    host_ack(1, 1'b0);
    tgl_m[1] = ~tgl_m[1];
    checks++;
    if (ep_done_o !== 3'b010) begin
      failures++;
      $display("FAIL bulk_ack2_done: actual=%b required=010", ep_done_o);
    end
  endtask

  task automatic test_nak();
    bit seen, held;
    set_src(2, 1'b0, 8'h00, 1'b0);
    set_src(1, 1'b1, 8'h77, 1'b1);
    send_token(2'b10, 7'd5, 4'd2);
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (hsk_send_o) seen = 1;
      else begin @(negedge clock); #1; end
    end
    checks++;
    if (!seen || hsk_type_o !== 2'b10) begin
      failures++;
      $display("FAIL nak_hsk: actual send=%b type=%b required send=1 type=10", hsk_send_o, hsk_type_o);
    end
    held = 1;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) begin tok_recv_i = 1'b1; tok_type_i = 2'b10; tok_addr_i = 7'd5; tok_endp_i = 4'd1; end
      else tok_recv_i = 1'b0;
      if (hsk_send_o !== 1'b1 || trn_send_o !== 1'b0) held = 0;
      @(negedge clock); #1;
    end
    tok_recv_i = 1'b0;
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL nak_hold: actual hsk_send=%b trn_send=%b required hsk_send=1 trn_send=0", hsk_send_o, trn_send_o);
    end
    hsk_sent_i = 1'b1;
    @(negedge clock);
    hsk_sent_i = 1'b0;
    #1;
    checks++;
    if (hsk_send_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL nak_release: actual hsk_send=%b busy=%b required 0/0", hsk_send_o, busy_o);
    end
    held = 1;
    for (int c = 0; c < 3; c++) begin
      if (busy_o !== 1'b0) held = 0;
      @(negedge clock); #1;
    end
    checks++;
    if (!held) begin
      failures++;
      $display("FAIL token_outside_idle: actual busy=1 required busy=0");
    end
`ifdef USB_IN_NAK_STATS_EN
    checks++;
    if (nak_count_o !== 24'h010000) begin
      failures++;
      $display("FAIL nak_count: actual=%h required=010000", nak_count_o);
    end
`endif
    set_src(1, 1'b0, 8'h00, 1'b0);
    run_packet(2, 2, tgl_m[2] ? 2'b10 : 2'b00);
    host_ack(2, 1'b0);
    tgl_m[2] = ~tgl_m[2];
  endtask

  task automatic test_stall();
    bit seen, trn_seen;
    ep_halt_i[0] = 1'b1;
    set_src(0, 1'b1, 8'h11, 1'b1);
    send_token(2'b10, 7'd5, 4'd0);
    seen = 0; trn_seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (trn_send_o) trn_seen = 1;
      if (hsk_send_o) seen = 1;
      else begin @(negedge clock); #1; end
    end
    checks++;
    if (!seen || hsk_type_o !== 2'b11 || trn_seen) begin
      failures++;
      $display("FAIL stall_hsk: actual send=%b type=%b trn_seen=%0d required send=1 type=11 trn_seen=0",
               hsk_send_o, hsk_type_o, trn_seen);
    end
    hsk_sent_i = 1'b1;
    @(negedge clock);
    hsk_sent_i = 1'b0;
    ep_halt_i = 3'b000;
    set_src(0, 1'b0, 8'h00, 1'b0);
    #1;
  endtask

  task automatic test_ack_timeout();
    int cnt;
    run_packet(1, 2, tgl_m[1] ? 2'b10 : 2'b00);
    cnt = 0;
    while (busy_o === 1'b1 && cnt < 2000) begin
      @(negedge clock); #1;
      cnt++;
    end
    checks++;
    if (cnt != ACK_TIMEOUT + 1 || ep_done_o !== 3'b000) begin
      failures++;
      $display("FAIL ack_timeout_cycles: actual=%0d done=%b required=%0d done=000", cnt, ep_done_o, ACK_TIMEOUT + 1);
    end
    run_packet(1, 2, tgl_m[1] ? 2'b10 : 2'b00);
    host_ack(1, 1'b0);
    tgl_m[1] = ~tgl_m[1];
    checks++;
    if (ep_done_o !== 3'b010) begin
      failures++;
      $display("FAIL replay_done: actual=%b required=010", ep_done_o);
    end
  endtask

  task automatic test_tgl_override();
    run_packet(0, 2, tgl_m[0] ? 2'b10 : 2'b00);
    host_ack(0, 1'b0);
    tgl_m[0] = ~tgl_m[0];
    run_packet(0, 2, tgl_m[0] ? 2'b10 : 2'b00);
    host_ack(0, 1'b1);
    tgl_m[0] = 1'b1;
    checks++;
    if (ep_done_o !== 3'b001) begin
      failures++;
      $display("FAIL ep0_ack_with_set_done: actual=%b required=001", ep_done_o);
    end
    run_packet(0, 2, tgl_m[0] ? 2'b10 : 2'b00);
    host_ack(0, 1'b0);
    tgl_m[0] = ~tgl_m[0];
    @(negedge clock);
    ep_tgl_clr_i[2] = 1'b1;
    @(negedge clock);
    ep_tgl_clr_i = 3'b000;
    tgl_m[2] = 1'b0;
    ep_tgl_clr_i[2] = 1'b1; ep_tgl_set_i[2] = 1'b1;
    @(negedge clock);
    ep_tgl_clr_i = 3'b000; ep_tgl_set_i = 3'b000;
    tgl_m[2] = 1'b1;
    #1;
    run_packet(2, 2, tgl_m[2] ? 2'b10 : 2'b00);
    host_ack(2, 1'b0);
    tgl_m[2] = ~tgl_m[2];
  endtask

  task automatic test_reset_mid();
    bit seen;
    set_src(1, 1'b1, 8'hC3, 1'b0);
    send_token(2'b10, 7'd5, 4'd1);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (trn_send_o) seen = 1;
      else begin @(negedge clock); #1; end
    end
    tx_tready_i = 1'b1;
    #1;
    checks++;
    if (!seen || trn_type_o !== (tgl_m[1] ? 2'b10 : 2'b00) || tx_tvalid_o !== 1'b1) begin
      failures++;
      $display("FAIL mid_xfer_setup: actual seen=%0d type=%b tvalid=%b required seen=1 type=%b tvalid=1",
               seen, trn_type_o, tx_tvalid_o, tgl_m[1] ? 2'b10 : 2'b00);
    end
    reset = 1'b1;
    @(negedge clock); #1;
    checks++;
    if ({hsk_send_o, hsk_type_o, trn_send_o, trn_type_o, tx_tvalid_o, tx_tlast_o, tx_tdata_o,
         ep_tready_o, ep_done_o, busy_o} !== 22'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs: actual trn=%b/%b tx=%b/%h rdy=%b busy=%b required all 0",
               trn_send_o, trn_type_o, tx_tvalid_o, tx_tdata_o, ep_tready_o, busy_o);
    end
    reset = 1'b0;
    tx_tready_i = 1'b0;
    set_src(1, 1'b0, 8'h00, 1'b0);
    tgl_m = 3'b000;
    @(negedge clock); #1;
    run_packet(1, 2, tgl_m[1] ? 2'b10 : 2'b00);
    host_ack(1, 1'b0);
    tgl_m[1] = ~tgl_m[1];
  endtask

  initial begin
    test_reset();
    test_ignored_tokens();
    test_bulk_ack();
    test_nak();
    test_stall();
    test_ack_timeout();
    test_tgl_override();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
